// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit with its own sequencer.
// MULT: radix-2 Booth, WIDTH iterations. DIV: restoring division on magnitudes
// plus sign fix-up, WIDTH iterations. Results land in hi/lo on entry to FINISH.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When defined, trivially-zero results
// skip the iterations and complete in cycle 1.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned AccW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {StIdle, StMult, StDiv, StFinish, StDzero} state_e;

    state_e state_q, state_d;

    // Accumulator layout: [2W:W+1] upper (partial product / remainder),
    // [W:1] lower (multiplier / quotient bits), [0] Booth's q(-1).
    logic [AccW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             b_zero, early_out, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_u, acc_l;
    logic [WIDTH:0]   booth_sum, div_part, div_diff;
    logic [AccW-1:0]  mult_step, div_step;
    logic [WIDTH-1:0] quo_mag, rem_mag;

    assign b_zero    = (b == '0);
    assign a_mag     = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag     = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic a_zero;
    assign a_zero    = (a == '0);
    assign early_out = op ? a_zero : (a_zero | b_zero);
`else
    assign early_out = 1'b0;
`endif

    // One iteration of each algorithm, computed from the current accumulator
    always_comb begin
        acc_u = acc_q[AccW-1:WIDTH+1];
        acc_l = acc_q[WIDTH:1];
        // Booth add/sub in W+1 bits so the shifted-in sign bit is always the true sign
        case (acc_q[1:0])
            2'b01:   booth_sum = {acc_u[WIDTH-1], acc_u} + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum = {acc_u[WIDTH-1], acc_u} - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum = {acc_u[WIDTH-1], acc_u};
        endcase
        // Arithmetic shift right of {sum, lower, q(-1)} drops q(-1) and keeps the rest
        mult_step = {booth_sum, acc_l};
        div_part  = {acc_u, acc_l[WIDTH-1]};
        div_diff  = div_part - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            div_step = {div_diff[WIDTH-1:0], acc_l[WIDTH-2:0], 1'b1, 1'b0};
        end else begin
            div_step = {div_part[WIDTH-1:0], acc_l[WIDTH-2:0], 1'b0, 1'b0};
        end
        quo_mag = div_step[WIDTH:1];
        rem_mag = div_step[AccW-1:WIDTH+1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; divide-by-zero takes precedence over early-out
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op && b_zero) begin
                        state_d = StDzero;
                    end else if (early_out) begin
                        state_d = StFinish;
                    end else if (op) begin
                        state_d = StDiv;
                    end else begin
                        state_d = StMult;
                    end
                end
            end
            StMult, StDiv: begin
                if (last_iter) begin
                    state_d = StFinish;
                end
            end
            StFinish, StDzero: state_d = StIdle;
            default:           state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StFinish);
        div_zero = (state_q == StDzero);
        hi       = hi_q;
        lo       = lo_q;
    end

    // Datapath next-state: operand capture, iteration, and result write-back
    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    opnd_d  = op ? b_mag : a;
                    acc_d   = op ? {{WIDTH{1'b0}}, a_mag, 1'b0} : {{WIDTH{1'b0}}, b, 1'b0};
                    q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    r_neg_d = a[WIDTH-1];
                    if (early_out && !(op && b_zero)) begin
                        hi_d = '0;
                        lo_d = '0;
                    end
                end
            end
            StMult: begin
                acc_d = mult_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    cnt_d = '0;
                    hi_d  = mult_step[AccW-1:WIDTH+1];
                    lo_d  = mult_step[WIDTH:1];
                end
            end
            StDiv: begin
                acc_d = div_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    cnt_d = '0;
                    // Quotient truncates toward zero; remainder follows the dividend sign
                    lo_d  = q_neg_q ? (~quo_mag + WIDTH'(1)) : quo_mag;
                    hi_d  = r_neg_q ? (~rem_mag + WIDTH'(1)) : rem_mag;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32) against a longint reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Reference: signed 64-bit arithmetic; SV division truncates toward zero
    function automatic void model(input logic op_i, input logic [W-1:0] a_i,
                                  input logic [W-1:0] b_i,
                                  output logic [W-1:0] mh, output logic [W-1:0] ml);
        longint sa, sb, p;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        if (!op_i) begin
            p  = sa * sb;
            mh = p[63:32];
            ml = p[31:0];
        end else begin
            p  = sa / sb;
            ml = p[31:0];
            p  = sa % sb;
            mh = p[31:0];
        end
    endfunction

    function automatic bit early_case(input logic op_i, input logic [W-1:0] a_i,
                                      input logic [W-1:0] b_i);
`ifdef MULDIV_EARLY_OUT_EN
        return op_i ? (a_i == 0) : (a_i == 0 || b_i == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Run one operation; optionally re-pulse start at cycle repulse_cyc (0 = never)
    task automatic do_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input int repulse_cyc, input string name);
        logic [W-1:0] mh, ml;
        bit dz, got_done, got_dz;
        int exp_cyc, got_cyc, bad_busy, k;
        dz = op_i && (b_i == 0);
        if (dz) begin
            mh      = exp_hi;
            ml      = exp_lo;
            exp_cyc = 1;
        end else begin
            model(op_i, a_i, b_i, mh, ml);
            exp_cyc = early_case(op_i, a_i, b_i) ? 1 : W + 1;
        end
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        got_done = 0;
        got_dz   = 0;
        got_cyc  = 0;
        bad_busy = 0;
        k        = 1;
        while (!got_done && !got_dz && k <= W + 8) begin
            if (busy !== 1'b1) bad_busy++;
            if (done === 1'b1) begin got_done = 1; got_cyc = k; end
            if (div_zero === 1'b1) begin got_dz = 1; got_cyc = k; end
            if (!got_done && !got_dz) begin
                start = (k == repulse_cyc);
                if (start) begin
                    op = 1'b1;
                    a  = $urandom;
                    b  = $urandom;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        checks++;
        if (dz ? (!got_dz || got_done || got_cyc != 1)
               : (!got_done || got_dz || got_cyc != exp_cyc)) begin
            failures++;
            $display("FAIL %s completion: got cycle=%0d done=%0b div_zero=%0b, want cycle=%0d %s",
                     name, got_cyc, got_done, got_dz, exp_cyc, dz ? "div_zero" : "done");
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL %s busy: low in %0d cycles, want high until completion", name, bad_busy);
        end
        checks++;
        if (hi !== mh) begin
            failures++;
            $display("FAIL %s hi: got %h want %h", name, hi, mh);
        end
        checks++;
        if (lo !== ml) begin
            failures++;
            $display("FAIL %s lo: got %h want %h", name, lo, ml);
        end
        exp_hi = mh;
        exp_lo = ml;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s after: got busy=%b done=%b div_zero=%b want 0 0 0",
                     name, busy, done, div_zero);
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("FAIL %s hold: got %h/%h want %h/%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset flags: got busy=%b done=%b div_zero=%b want 0 0 0",
                     busy, done, div_zero);
        end
        checks++;
        if (hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL reset hilo: got %h/%h want 0/0", hi, lo);
        end
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, "mult_7_m3");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mult_7_m3 value: got %h/%h want ffffffff/ffffffeb", hi, lo);
        end
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 0, "div_100_m7");
        checks++;
        if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFF2) begin
            failures++;
            $display("FAIL div_100_m7 value: got %h/%h want 00000002/fffffff2", hi, lo);
        end
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, "div_m100_7");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin
            failures++;
            $display("FAIL div_m100_7 value: got %h/%h want fffffffe/fffffff2", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        do_op(1'b1, 32'd5, 32'd2, 0, "div_5_2");
        do_op(1'b1, 32'd5, 32'd0, 0, "div_5_0");
        checks++;
        if (hi !== 32'd1 || lo !== 32'd2) begin
            failures++;
            $display("FAIL div_5_0 value: got %h/%h want 00000001/00000002", hi, lo);
        end
    endtask

    task automatic test_overflow();
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_min_m1 value: got %h/%h want 00000000/80000000", hi, lo);
        end
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min_min");
        checks++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            failures++;
            $display("FAIL mult_min_min value: got %h/%h want 40000000/00000000", hi, lo);
        end
    endtask

    task automatic test_start_while_busy();
        do_op(1'b0, 32'd123457, 32'hFFFF_0001, 5, "busy_restart");
    endtask

    task automatic test_reset_abort();
        int done_seen;
        start = 1'b1;
        op    = 1'b0;
        a     = $urandom | 32'h1;
        b     = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL abort state: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        exp_hi = '0;
        exp_lo = '0;
        done_seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort no_done: got done pulses=%0d busy=%b want 0 0", done_seen, busy);
        end
    endtask

    task automatic test_early_out();
        do_op(1'b0, 32'd0, 32'd1234, 0, "mult_zero");
        do_op(1'b1, 32'd0, 32'd9, 0, "div_zero_dividend");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            do_op(1'($urandom), pick(), pick(), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_overflow();
        test_start_while_busy();
        test_reset_abort();
        test_early_out();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
